// File: rtl/inst_sram_responder_pkg.sv
// inst_sram_responder_pkg: shared SRAM interface constants for fetch and responder
package inst_sram_responder_pkg;
  localparam logic [3:0] SRAM_WE_NONE = 4'b0000;
  localparam logic [3:0] SRAM_WE_WORD = 4'b1111;
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] RESET_PC = 32'h1bff_fffc;
endpackage

// File: rtl/sram_byte_merge.sv
// sram_byte_merge: per-lane merge of write data into an existing word
module sram_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] new_word
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign new_word[8*i+:8] = we[i] ? wdata[8*i+:8] : old_word[8*i+:8];
  end
endmodule

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: 1-cycle read-first SRAM window with byte writes, preload and access counters
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = ADDR_BASE_DEFAULT,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] OOR_DATA   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sram_en,
  input  logic [3:0]            sram_we,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  output logic                  sram_oor,
  input  logic                  pre_en,
  input  logic [DEPTH_LOG2-1:0] pre_addr,
  input  logic [31:0]           pre_wdata,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0] mem [DEPTH];
  logic [31:0] off, old_word, new_word;
  logic [DEPTH_LOG2-1:0] idx;
  logic in_range, is_rd, is_wr, unused_ok;
  // addresses below the base wrap to a huge offset and fall out of range
  assign off = sram_addr - ADDR_BASE;
  assign idx = off[DEPTH_LOG2+1:2];
  assign in_range = off[31:DEPTH_LOG2+2] == '0;
  assign unused_ok = ^off[1:0];
  assign old_word = mem[idx];
  assign is_rd = sram_en && sram_we == SRAM_WE_NONE && in_range;
  assign is_wr = sram_en && sram_we != SRAM_WE_NONE && in_range;
  sram_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (sram_wdata),
    .we       (sram_we),
    .new_word (new_word)
  );
  always_ff @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_wdata;
    else if (is_wr) mem[idx] <= new_word;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_rdata <= '0;
      sram_oor   <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      if (sram_en) begin
        sram_rdata <= in_range ? old_word : OOR_DATA;
        sram_oor   <= ~in_range;
      end
      if (is_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
      if (is_wr && !pre_en && wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: directed plan plus random traffic against a word-array reference model
module tb_inst_sram_responder;
  import inst_sram_responder_pkg::*;
  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam int WORDS = 1024;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sram_en = 1'b0;
  logic [3:0] sram_we = '0;
  logic [31:0] sram_addr = '0, sram_wdata = '0;
  logic [31:0] sram_rdata, rd_cnt, wr_cnt;
  logic sram_oor;
  logic pre_en = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [31:0] pre_wdata = '0;
  logic [31:0] ref_mem [WORDS];
  logic [31:0] m_rdata = '0, m_rd = '0, m_wr = '0;
  logic m_oor = 1'b0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  inst_sram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_oor   (sram_oor),
    .pre_en     (pre_en),
    .pre_addr   (pre_addr),
    .pre_wdata  (pre_wdata),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // one clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic pe, input logic [9:0] pa,
                       input logic [31:0] pd);
    logic [31:0] w;
    bit inr;
    w = (addr - BASE) >> 2;
    inr = w < WORDS;
    sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
    pre_en = pe; pre_addr = pa; pre_wdata = pd;
    if (resetn && en) begin
      m_rdata = inr ? ref_mem[w[9:0]] : 32'h0;
      m_oor = !inr;
      if (we == 4'h0) begin
        if (inr && m_rd != 32'hFFFF_FFFF) m_rd++;
      end else if (inr && !pe) begin
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[w[9:0]][8*b+:8] = wdata[8*b+:8];
        if (m_wr != 32'hFFFF_FFFF) m_wr++;
      end
    end
    if (pe) ref_mem[pa] = pd;
    @(posedge clk);
    #1;
    chk("rdata", sram_rdata, m_rdata);
    chk("oor", {31'b0, sram_oor}, {31'b0, m_oor});
    chk("rd_cnt", rd_cnt, m_rd);
    chk("wr_cnt", wr_cnt, m_wr);
  endtask
  task automatic rd(input logic [31:0] addr);
    cycle(1'b1, SRAM_WE_NONE, addr, 32'h0, 1'b0, 10'd0, 32'h0);
  endtask
  task automatic idle();
    cycle(1'b0, SRAM_WE_NONE, 32'h0, 32'h0, 1'b0, 10'd0, 32'h0);
  endtask
  initial begin
    logic [31:0] wr_before, a;
    for (int i = 0; i < WORDS; i++)
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 10'(i), $urandom);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 10'd0, 32'h0280_0413);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 10'd1, 32'h1234_5678);
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_rd_cnt", rd_cnt, 32'h0);
    resetn = 1'b1;
    rd(32'h1c00_0000);
    chk("tp_read0", sram_rdata, 32'h0280_0413);
    chk("tp_read0_oor", {31'b0, sram_oor}, 32'h0);
    chk("tp_read0_cnt", rd_cnt, 32'h1);
    cycle(1'b1, 4'b0101, 32'h1c00_0004, 32'hAABB_CCDD, 1'b0, 10'd0, 32'h0);
    chk("tp_wr_old", sram_rdata, 32'h1234_5678);
    rd(32'h1c00_0004);
    chk("tp_merge", sram_rdata, 32'h12BB_56DD);
    chk("tp_wr_cnt", wr_cnt, 32'h1);
    rd(32'h1bff_fffc);
    chk("tp_below", sram_rdata, 32'h0);
    chk("tp_below_oor", {31'b0, sram_oor}, 32'h1);
    rd(32'h1c00_1000);
    chk("tp_above", sram_rdata, 32'h0);
    chk("tp_above_oor", {31'b0, sram_oor}, 32'h1);
    chk("tp_oor_rd_cnt", rd_cnt, 32'h2);
    rd(32'h1c00_0000);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("tp_hold", sram_rdata, 32'h0280_0413);
    end
    wr_before = wr_cnt;
    cycle(1'b1, SRAM_WE_WORD, 32'h1c00_0008, 32'h2, 1'b1, 10'd2, 32'h1);
    rd(32'h1c00_0008);
    chk("tp_pre_prio", sram_rdata, 32'h1);
    chk("tp_pre_wr_cnt", wr_cnt, wr_before);
    sram_en = 1'b1; sram_we = SRAM_WE_NONE; sram_addr = 32'h1c00_0004;
    #2 resetn = 1'b0;
    sram_en = 1'b0;
    m_rdata = '0; m_oor = 1'b0; m_rd = '0; m_wr = '0;
    #1;
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_oor", {31'b0, sram_oor}, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    #1 resetn = 1'b1;
    rd(32'h1c00_0004);
    chk("rst_keep_mem", sram_rdata, 32'h12BB_56DD);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: a = BASE - 4 * $urandom_range(1, 4);
        1: a = BASE + 32'h1000 + 4 * $urandom_range(0, 4);
        2: a = $urandom;
        default: a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(0, 3);
      endcase
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
            a, $urandom, $urandom_range(0, 7) == 0, 10'($urandom), $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder end of the inst_sram/data_sram single-port SRAM interface driven by the fetch stage (en, we[3:0], addr, wdata, rdata).
- Models a synchronous word-organised memory window:
  - 1-cycle read latency
  - byte-lane writes
  - out-of-range detection
  - access counters
- Also has a preload port so the bench or boot logic can fill the array before the core leaves reset.

Parameters:
- ADDR_BASE, 32'h1c000000, byte address mapped to word 0 (first fetch after PC reset value 32'h1bfffffc).
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words = 4 KiB).
- OOR_DATA, 32'h0000_0000, rdata returned for an out-of-range read.

Ports:
- clk  input  1  system clock, all logic on posedge
- resetn  input  1  asynchronous, active-low reset
- sram_en  input  1  access request this cycle
- sram_we  input  4  byte write enables; 4'b0000 = read
- sram_addr  input  32  byte address; bits [1:0] ignored
- sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
- sram_rdata  output  32  read data, valid the cycle after a read request
- sram_oor  output  1  registered flag: previous accepted access was out of range
- pre_en  input  1  preload write strobe (full-word write)
- pre_addr  input  DEPTH_LOG2  preload word index
- pre_wdata  input  32  preload data
- rd_cnt  output  32  count of in-range reads accepted
- wr_cnt  output  32  count of in-range writes accepted (any we != 0)

Behaviour:
- Reset (resetn=0, asynchronous):
  - sram_rdata=0, sram_oor=0, rd_cnt=0, wr_cnt=0.
  - Array contents are NOT reset.
- Word index:
  - off = sram_addr - ADDR_BASE (32-bit wrap arithmetic).
  - in_range = (off >> 2) < 2**DEPTH_LOG2.
  - idx = off[DEPTH_LOG2+1:2].
- Read (en=1, we=0):
  - sram_rdata <= in_range ? mem[idx] : OOR_DATA on next posedge.
  - sram_oor <= ~in_range.
  - rd_cnt += in_range.
- Write (en=1, we!=0):
  - If in_range, each lane i with we[i]=1 is updated in mem[idx]; other lanes are kept.
  - sram_rdata <= old mem[idx] (read-first) if in_range, else OOR_DATA.
  - sram_oor <= ~in_range.
  - wr_cnt += in_range.
  - An out-of-range write is dropped with no side effect on the array.
- Idle (en=0):
  - sram_rdata and sram_oor hold their previous values indefinitely.
  - The fetch stage relies on this hold while it is stalled.
- Preload:
  - pre_en=1 writes pre_wdata to mem[pre_addr], all lanes.
  - Preload has priority: if pre_en and en with we!=0 occur the same cycle, the sram write is dropped and wr_cnt is not incremented.
  - An sram read in the same cycle still completes and returns the pre-write (old) value.
  - Preload does not touch counters, rdata or oor.
- Back-to-back: a write to word W at cycle t followed by a read of W at t+1 returns the merged new word at t+2.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- Reset asserted mid-access: the outputs clear immediately and the in-flight response is lost. The array keeps whatever was written on prior edges.
- Addresses below ADDR_BASE wrap to a large off, so they are out of range.

Decomposition:
- Shared package holds:
  - SRAM_WE_NONE = 4'b0000
  - SRAM_WE_WORD = 4'b1111
  - default ADDR_BASE / reset-PC constants, so fetch and responder agree.
- One sub-module, sram_byte_merge: a combinational lane merge (old, wdata, we -> new) that the data-side responder will reuse.
- Counters stay inline.

Test Plan:
- Preload mem[0]=32'h02800413, mem[1]=32'h1234_5678, release resetn, en=1 we=0 addr=32'h1c000000 -> next cycle rdata=32'h02800413, oor=0, rd_cnt=1.
- Write addr=32'h1c000004 we=4'b0101 wdata=32'hAABB_CCDD over 32'h1234_5678 -> rdata that cycle+1 =32'h1234_5678; following read -> 32'h12BB_56DD, wr_cnt=1.
- Read addr=32'h1bfffffc, then addr=32'h1c001000 (DEPTH_LOG2=10) -> rdata=32'h0, oor=1 each time, rd_cnt unchanged.
- Read of mem[0], then en=0 for 5 cycles -> rdata stays 32'h02800413 every cycle.
- Same cycle pre_en=1 pre_addr=2 pre_wdata=32'h1 and en=1 we=4'hF addr=32'h1c000008 wdata=32'h2 -> later read gives 32'h1, wr_cnt unchanged.
- Assert resetn=0 between posedges during an active read -> rdata, oor, counters 0 before the next edge; after release, read of mem[1] still returns 32'h12BB_56DD.
